// File: rtl/bram_axil_master_if.sv
`default_nettype none
// ============================================================================
// bram_axil_master_if: AR/R/AW/W/B channel bundle between the BRAM initiator
// and the BRAM read/write responders.            Rev 1.0
// ============================================================================
interface bram_axil_master_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arready;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic                  rready;
    logic                  awvalid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awready;
    logic                  wvalid;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, awready, wready, bvalid
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, awready, wready, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/bram_axil_master.sv
`default_nettype none
// ============================================================================
// bram_axil_master: turns single load/store requests into one outstanding BRAM
// bus transaction, with misalignment check and bus-wait timeout.   Rev 1.0
// ============================================================================
module bram_axil_master #(
    parameter int ADDR_WIDTH     = 15,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  req_valid,
    output logic                       req_ready,
    input  wire logic                  req_we,
    input  wire logic [ADDR_WIDTH+1:0] req_addr,
    input  wire logic [31:0]           req_wdata,
    input  wire logic [3:0]            req_wstrb,
    output logic                       resp_valid,
    output logic [31:0]                resp_rdata,
    output logic                       resp_err,
    bram_axil_master_if.master         bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          aw_done, w_done, b_seen, resp_pend;
    logic          ar_hs, aw_ok, w_ok, b_ok, timeout_hit;
    logic          fin, fin_err;
    logic [31:0]   fin_data;

    // Completion (normal or timeout) of the current bus-wait state.
    always_comb begin
        ar_hs       = bus.arvalid && bus.arready;
        aw_ok       = aw_done || (bus.awvalid && bus.awready);
        w_ok        = w_done || (bus.wvalid && bus.wready);
        b_ok        = b_seen || bus.bvalid;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
        fin         = 1'b0;
        fin_err     = 1'b0;
        fin_data    = '0;
        case (state)
            RD_ADDR: begin
                if (ar_hs && bus.rvalid) begin
                    fin      = 1'b1;
                    fin_data = bus.rdata;
                end else if (!ar_hs && timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            RD_DATA: begin
                if (bus.rvalid) begin
                    fin      = 1'b1;
                    fin_data = bus.rdata;
                end else if (timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            WR_REQ: begin
                if (aw_ok && w_ok) begin
                    fin = b_ok;
                end else if (timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            WR_RESP: begin
                if (bus.bvalid) begin
                    fin = 1'b1;
                end else if (timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            resp_pend   <= 1'b0;
            cnt         <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            b_seen      <= 1'b0;
            bus.arvalid <= 1'b0;
            bus.araddr  <= '0;
            bus.rready  <= 1'b0;
            bus.awvalid <= 1'b0;
            bus.awaddr  <= '0;
            bus.wvalid  <= 1'b0;
            bus.wdata   <= '0;
            bus.wstrb   <= '0;
            bus.bready  <= 1'b0;
        end else begin
            if (state != IDLE && state != RESP && cnt != '1)
                cnt <= cnt + CW'(1);
            if (fin) begin
                state       <= RESP;
                resp_valid  <= 1'b1;
                resp_err    <= fin_err;
                resp_rdata  <= fin_data;
                bus.arvalid <= 1'b0;
                bus.rready  <= 1'b0;
                bus.awvalid <= 1'b0;
                bus.wvalid  <= 1'b0;
                bus.bready  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid && req_ready) begin
                            req_ready  <= 1'b0;
                            cnt        <= '0;
                            bus.araddr <= req_addr[ADDR_WIDTH+1:2];
                            bus.awaddr <= req_addr[ADDR_WIDTH+1:2];
                            bus.wdata  <= req_wdata;
                            bus.wstrb  <= req_wstrb;
                            if (req_addr[1:0] != 2'b00) begin
                                // Misaligned: no bus traffic, response one cycle later.
                                state      <= RESP;
                                resp_pend  <= 1'b1;
                                resp_err   <= 1'b1;
                                resp_rdata <= '0;
                            end else if (req_we) begin
                                state       <= WR_REQ;
                                bus.awvalid <= 1'b1;
                                bus.wvalid  <= 1'b1;
                                bus.bready  <= 1'b1;
                                aw_done     <= 1'b0;
                                w_done      <= 1'b0;
                                b_seen      <= 1'b0;
                            end else begin
                                state       <= RD_ADDR;
                                bus.arvalid <= 1'b1;
                                bus.rready  <= 1'b1;
                            end
                        end
                    end
                    RD_ADDR: begin
                        if (ar_hs) begin
                            bus.arvalid <= 1'b0;
                            state       <= RD_DATA;
                            cnt         <= '0;
                        end
                    end
                    WR_REQ: begin
                        if (bus.awvalid && bus.awready) begin
                            bus.awvalid <= 1'b0;
                            aw_done     <= 1'b1;
                        end
                        if (bus.wvalid && bus.wready) begin
                            bus.wvalid <= 1'b0;
                            w_done     <= 1'b1;
                        end
                        if (bus.bvalid)
                            b_seen <= 1'b1;
                        if (aw_ok && w_ok) begin
                            state <= WR_RESP;
                            cnt   <= '0;
                        end
                    end
                    RESP: begin
                        if (resp_pend) begin
                            resp_pend  <= 1'b0;
                            resp_valid <= 1'b1;
                        end else begin
                            resp_valid <= 1'b0;
                            req_ready  <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                    RD_DATA, WR_RESP: ;
                    default: begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bram_axil_master.sv
`default_nettype none
// ============================================================================
// tb_bram_axil_master: scoreboard bench with a registered zero-wait responder.
// Rev 1.0
// ============================================================================
module tb_bram_axil_master;
    localparam int ADDR_WIDTH     = 15;
    localparam int TIMEOUT_CYCLES = 8;

    typedef struct {
        logic [31:0]           rdata;
        logic                  err;
        int                    lat;
        int                    ar_cyc;
        int                    aw_cyc;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_we = 1'b0;
    logic [ADDR_WIDTH+1:0] req_addr = '0;
    logic [31:0]           req_wdata = '0;
    logic [3:0]            req_wstrb = '0;
    logic                  req_ready, resp_valid, resp_err;
    logic [31:0]           resp_rdata;

    logic        ar_en = 1'b1, rv_en = 1'b1, aw_en = 1'b1;
    logic [31:0] rd_value = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    bram_axil_master_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    bram_axil_master #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Responder answers one cycle after seeing valid, so it re-fires once after valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
        end else begin
            bus.arready <= ar_en && bus.arvalid;
            bus.rvalid  <= rv_en && bus.arvalid;
            bus.rdata   <= rd_value;
            bus.awready <= aw_en && bus.awvalid && bus.wvalid;
            bus.wready  <= aw_en && bus.awvalid && bus.wvalid;
            bus.bvalid  <= aw_en && bus.awvalid && bus.wvalid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   acc_cyc = 0, ar_cnt = 0, aw_cnt = 0;
        bit   pa = 0, pw = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pa = 0;
                pw = 0;
            end else begin
                if (req_valid && req_ready) begin
                    acc_cyc = cyc;
                    ar_cnt  = 0;
                    aw_cnt  = 0;
                end
                if (bus.arvalid) begin
                    ar_cnt++;
                    if (!pa && sb.size() > 0)
                        check("araddr", 32'(bus.araddr), 32'(sb[0].addr));
                end
                if (bus.awvalid) begin
                    aw_cnt++;
                    if (!pw && sb.size() > 0) begin
                        check("wvalid_with_awvalid", 32'(bus.wvalid), 32'(1));
                        check("awaddr", 32'(bus.awaddr), 32'(sb[0].addr));
                        check("wdata", bus.wdata, sb[0].wdata);
                        check("wstrb", 32'(bus.wstrb), 32'(sb[0].wstrb));
                    end
                end
                pa = bus.arvalid;
                pw = bus.awvalid;
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_resp", 32'(resp_valid), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_err", 32'(resp_err), 32'(e.err));
                        check("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                        check("arvalid_cycles", 32'(ar_cnt), 32'(e.ar_cyc));
                        check("awvalid_cycles", 32'(aw_cnt), 32'(e.aw_cyc));
                    end
                end
            end
        end
    end

    task automatic send(input logic we, input logic [ADDR_WIDTH+1:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input int arc, input int awc, input bit track);
        exp_t e;
        int   n = 0;
        @(posedge clk);
        #1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        rd_value  = rd;
        e.rdata   = exp_rd;
        e.err     = exp_err;
        e.lat     = lat;
        e.ar_cyc  = arc;
        e.aw_cyc  = awc;
        e.addr    = addr[ADDR_WIDTH+1:2];
        e.wdata   = wd;
        e.wstrb   = ws;
        if (track)
            sb.push_back(e);
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("resp_wait", 32'(sb.size()), 32'(0));
        sb.delete();
        repeat (3) @(posedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_arvalid", 32'(bus.arvalid), 32'(0));
        check("rst_aw_w_valid", 32'({bus.awvalid, bus.wvalid}), 32'(0));
        check("rst_ready_outs", 32'({bus.rready, bus.bready}), 32'(0));
        check("rst_resp", 32'({resp_valid, resp_err}), 32'(0));
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_addr", 32'({bus.araddr, bus.awaddr}), 32'(0));
        check("rst_wdata", bus.wdata, 32'h0);
        check("rst_wstrb", 32'(bus.wstrb), 32'(0));
        rst = 1'b0;

        // we, addr, wdata, wstrb, rd, exp_rd, exp_err, lat, ar, aw, track
        send(1'b0, 17'h00010, 32'h0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3, 2, 0, 1'b1);
        wait_done();
        send(1'b1, 17'h00008, 32'h12345678, 4'b0101, 32'h0, 32'h0, 1'b0, 3, 0, 2, 1'b1);
        wait_done();
        send(1'b0, 17'h1FFFC, 32'h0, 4'h0, 32'hA5A50F0F, 32'hA5A50F0F, 1'b0, 3, 2, 0, 1'b1);
        wait_done();
        send(1'b1, 17'h1FFFC, 32'hCAFEF00D, 4'b1000, 32'h0, 32'h0, 1'b0, 3, 0, 2, 1'b1);
        wait_done();
        send(1'b0, 17'h00002, 32'h0, 4'h0, 32'h11111111, 32'h0, 1'b1, 2, 0, 0, 1'b1);
        wait_done();
        send(1'b1, 17'h00005, 32'h55AA55AA, 4'hF, 32'h0, 32'h0, 1'b1, 2, 0, 0, 1'b1);
        wait_done();

        ar_en = 1'b0;
        send(1'b0, 17'h00020, 32'h0, 4'h0, 32'h77777777, 32'h0, 1'b1,
             TIMEOUT_CYCLES + 1, TIMEOUT_CYCLES, 0, 1'b1);
        wait_done();
        ar_en = 1'b1;
        send(1'b0, 17'h00024, 32'h0, 4'h0, 32'h13579BDF, 32'h13579BDF, 1'b0, 3, 2, 0, 1'b1);
        wait_done();

        aw_en = 1'b0;
        send(1'b1, 17'h00040, 32'h0BADF00D, 4'hF, 32'h0, 32'h0, 1'b1,
             TIMEOUT_CYCLES + 1, 0, TIMEOUT_CYCLES, 1'b1);
        wait_done();
        aw_en = 1'b1;
        send(1'b1, 17'h00044, 32'h89ABCDEF, 4'b0011, 32'h0, 32'h0, 1'b0, 3, 0, 2, 1'b1);
        wait_done();

        // Park a read in RD_DATA, then reset it away.
        rv_en = 1'b0;
        send(1'b0, 17'h00030, 32'h0, 4'h0, 32'h22222222, 32'h0, 1'b0, 0, 0, 0, 1'b0);
        n = 0;
        while (!(bus.rready && !bus.arvalid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_rd_data", 32'(bus.rready && !bus.arvalid), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rv_en = 1'b1;
        check("rst_mid_arvalid", 32'(bus.arvalid), 32'(0));
        check("rst_mid_rready", 32'(bus.rready), 32'(0));
        check("rst_mid_req_ready", 32'(req_ready), 32'(1));
        check("rst_mid_resp_valid", 32'(resp_valid), 32'(0));
        repeat (6) @(posedge clk);

        send(1'b0, 17'h00100, 32'h0, 4'h0, 32'hFEEDFACE, 32'hFEEDFACE, 1'b0, 3, 2, 0, 1'b1);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
